mem_bus_arbiter: RTL and testbench

- Sequences and shares the CPU's single Avalon memory-mapped master port between two requesters: the instruction-fetch path and the load/store data path.
- Arbitrates round-robin and holds bus signals stable across waitrequest.
- Generates byteenable and lane steering for byte, half and word accesses, and converts between the little-endian bus and the big-endian core.
- Sits between fsm/control and the top-level bus pins, and supplies the stall condition used for waitrequest stalls.

---
 rtl/mem_bus_arbiter_pkg.sv | 40 ++++
 rtl/mem_bus_arbiter_lane_steer.sv | 54 +++++
 rtl/mem_bus_arbiter.sv | 195 +++++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and helpers for the memory bus arbiter.
package mem_bus_arbiter_pkg;

   localparam int unsigned BUS_DATA_W = 32;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'd0,
      SZ_HALF = 2'd1,
      SZ_WORD = 2'd2
   } mem_size_t;

   typedef enum logic [1:0] {
      IDLE,
      BUS,
      DONE
   } arb_state_t;

   typedef enum logic {
      GNT_FETCH,
      GNT_DATA
   } grant_t;

   // Big-endian core word <-> little-endian bus word.
   function automatic logic [31:0] swap_endian(input logic [31:0] i_d);
      return {i_d[7:0], i_d[15:8], i_d[23:16], i_d[31:24]};
   endfunction

   // Misaligned half/word or reserved size.
   function automatic logic access_err(input logic [1:0] i_size, input logic [1:0] i_off);
      logic w_err;
      case (i_size)
         SZ_BYTE: w_err = 1'b0;
         SZ_HALF: w_err = i_off[0];
         SZ_WORD: w_err = (i_off != 2'b00);
         default: w_err = 1'b1;
      endcase
      return w_err;
   endfunction

endpackage

// File: rtl/mem_bus_arbiter_lane_steer.sv
// Byte-lane steering: byteenable, store lane placement and load extraction/extension.
module mem_bus_arbiter_lane_steer
   import mem_bus_arbiter_pkg::*;
(
   input  logic [1:0]  i_size,
   input  logic [1:0]  i_off,
   input  logic        i_signed,
   input  logic [31:0] i_wdata,
   input  logic [31:0] i_rdata,
   output logic [3:0]  o_be,
   output logic [31:0] o_wdata,
   output logic [31:0] o_rdata
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   // Map access size and lane offset to enables, bus write data and extended load result.
   always_comb begin
      o_be    = '0;
      o_wdata = '0;
      o_rdata = '0;
      w_byte  = 8'(i_rdata >> {i_off, 3'b000});
      w_half  = '0;
      case (i_size)
         SZ_BYTE: begin
            o_be    = 4'b0001 << i_off;
            o_wdata = {24'b0, i_wdata[7:0]} << {i_off, 3'b000};
            o_rdata = {{24{i_signed & w_byte[7]}}, w_byte};
         end
         SZ_HALF: begin
            if (i_off[1]) begin
               o_be    = 4'b1100;
               o_wdata = {i_wdata[7:0], i_wdata[15:8], 16'b0};
               w_half  = {i_rdata[23:16], i_rdata[31:24]};
            end else begin
               o_be    = 4'b0011;
               o_wdata = {16'b0, i_wdata[7:0], i_wdata[15:8]};
               w_half  = {i_rdata[7:0], i_rdata[15:8]};
            end
            o_rdata = {{16{i_signed & w_half[15]}}, w_half};
         end
         SZ_WORD: begin
            o_be    = 4'b1111;
            o_wdata = swap_endian(i_wdata);
            o_rdata = swap_endian(i_rdata);
         end
         default: begin
            o_be    = '0;
         end
      endcase
   end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one Avalon-MM master between instruction fetch and load/store.
module mem_bus_arbiter
   import mem_bus_arbiter_pkg::*;
#(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset_i,
   input  logic              fetch_req_i,
   input  logic [ADDR_W-1:0] fetch_addr_i,
   output logic              fetch_done_o,
   output logic [DATA_W-1:0] fetch_data_o,
   input  logic              data_req_i,
   input  logic              data_we_i,
   input  logic [1:0]        data_size_i,
   input  logic              data_signed_i,
   input  logic [ADDR_W-1:0] data_addr_i,
   input  logic [DATA_W-1:0] data_wdata_i,
   output logic              data_done_o,
   output logic [DATA_W-1:0] data_rdata_o,
   output logic              data_err_o,
   output logic              busy_o,
   output logic [ADDR_W-1:0] address_o,
   output logic              read_o,
   output logic              write_o,
   input  logic              waitrequest_i,
   output logic [DATA_W-1:0] writedata_o,
   output logic [3:0]        byteenable_o,
   input  logic [DATA_W-1:0] readdata_i
);

   arb_state_t        r_state;
   arb_state_t        w_next;
   grant_t            r_last;
   grant_t            r_gnt;
   grant_t            w_grant;
   logic              w_fire;
   logic              w_err;

   logic [1:0]        r_size;
   logic [1:0]        r_off;
   logic              r_signed;
   logic              r_we;
   logic [DATA_W-1:0] r_wdata;
   logic [ADDR_W-1:0] r_address;
   logic              r_read;
   logic              r_write;
   logic              r_fetch_done;
   logic [DATA_W-1:0] r_fetch_data;
   logic              r_data_done;
   logic [DATA_W-1:0] r_data_rdata;
   logic              r_data_err;

   logic [3:0]        w_be;
   logic [DATA_W-1:0] w_wdata;
   logic [DATA_W-1:0] w_rdata;
   logic              w_unused_fetch_lsb;

   // Fetches are always word-aligned word reads; the low address bits are dropped.
   assign w_unused_fetch_lsb = ^fetch_addr_i[1:0];

   mem_bus_arbiter_lane_steer u_lane_steer (
      .i_size   (r_size),
      .i_off    (r_off),
      .i_signed (r_signed),
      .i_wdata  (r_wdata),
      .i_rdata  (readdata_i),
      .o_be     (w_be),
      .o_wdata  (w_wdata),
      .o_rdata  (w_rdata)
   );

   // Next-state and grant selection; requests are only looked at in IDLE.
   always_comb begin
      w_next  = r_state;
      w_grant = r_gnt;
      w_fire  = 1'b0;
      w_err   = 1'b0;
      case (r_state)
         IDLE: begin
            if (fetch_req_i && data_req_i) begin
               w_grant = (r_last == GNT_FETCH) ? GNT_DATA : GNT_FETCH;
            end else if (fetch_req_i) begin
               w_grant = GNT_FETCH;
            end else if (data_req_i) begin
               w_grant = GNT_DATA;
            end
            w_fire = fetch_req_i | data_req_i;
            if (w_fire) begin
               w_err  = (w_grant == GNT_DATA) && access_err(data_size_i, data_addr_i[1:0]);
               w_next = w_err ? DONE : BUS;
            end
         end
         BUS: begin
            if (!waitrequest_i) begin
               w_next = DONE;
            end
         end
         DONE: begin
            w_next = IDLE;
         end
         default: begin
            w_next = IDLE;
         end
      endcase
   end

   // State register and round-robin history.
   always_ff @(posedge clk or negedge reset_i) begin
      if (!reset_i) begin
         r_state <= IDLE;
         r_last  <= GNT_DATA;
      end else begin
         r_state <= w_next;
         if (w_fire) begin
            r_last <= w_grant;
         end
      end
   end

   // Payload latch, registered bus strobes and completion outputs.
   always_ff @(posedge clk or negedge reset_i) begin
      if (!reset_i) begin
         r_gnt        <= GNT_DATA;
         r_size       <= '0;
         r_off        <= '0;
         r_signed     <= 1'b0;
         r_we         <= 1'b0;
         r_wdata      <= '0;
         r_address    <= '0;
         r_read       <= 1'b0;
         r_write      <= 1'b0;
         r_fetch_done <= 1'b0;
         r_fetch_data <= '0;
         r_data_done  <= 1'b0;
         r_data_rdata <= '0;
         r_data_err   <= 1'b0;
      end else begin
         r_fetch_done <= 1'b0;
         r_data_done  <= 1'b0;
         if (w_fire) begin
            r_gnt <= w_grant;
            if (w_grant == GNT_FETCH) begin
               r_size    <= SZ_WORD;
               r_off     <= '0;
               r_signed  <= 1'b0;
               r_we      <= 1'b0;
               r_wdata   <= '0;
               r_address <= {fetch_addr_i[ADDR_W-1:2], 2'b00};
               r_read    <= 1'b1;
            end else begin
               r_size    <= data_size_i;
               r_off     <= data_addr_i[1:0];
               r_signed  <= data_signed_i;
               r_we      <= data_we_i;
               r_wdata   <= data_wdata_i;
               r_address <= {data_addr_i[ADDR_W-1:2], 2'b00};
               if (w_err) begin
                  r_data_done  <= 1'b1;
                  r_data_err   <= 1'b1;
                  r_data_rdata <= '0;
               end else begin
                  r_read  <= ~data_we_i;
                  r_write <= data_we_i;
               end
            end
         end else if (r_state == BUS && !waitrequest_i) begin
            r_read  <= 1'b0;
            r_write <= 1'b0;
            if (r_gnt == GNT_FETCH) begin
               r_fetch_done <= 1'b1;
               r_fetch_data <= swap_endian(readdata_i);
            end else begin
               r_data_done  <= 1'b1;
               r_data_err   <= 1'b0;
               r_data_rdata <= r_we ? '0 : w_rdata;
            end
         end
      end
   end

   assign fetch_done_o = r_fetch_done;
   assign fetch_data_o = r_fetch_data;
   assign data_done_o  = r_data_done;
   assign data_rdata_o = r_data_rdata;
   assign data_err_o   = r_data_err;
   assign busy_o       = (r_state != IDLE);
   assign address_o    = r_address;
   assign read_o       = r_read;
   assign write_o      = r_write;
   assign byteenable_o = (r_read | r_write) ? w_be : '0;
   assign writedata_o  = r_write ? w_wdata : '0;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: directed requests, queued expectations, decoupled monitors.
module tb_mem_bus_arbiter;

   typedef struct {
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] wd;
      logic        we;
   } bus_exp_t;

   typedef struct {
      bit          is_fetch;
      logic [31:0] data;
      logic        err;
      int          cyc;
   } resp_exp_t;

   logic        clk = 1'b0;
   logic        reset_i;
   logic        fetch_req_i;
   logic [31:0] fetch_addr_i;
   logic        fetch_done_o;
   logic [31:0] fetch_data_o;
   logic        data_req_i;
   logic        data_we_i;
   logic [1:0]  data_size_i;
   logic        data_signed_i;
   logic [31:0] data_addr_i;
   logic [31:0] data_wdata_i;
   logic        data_done_o;
   logic [31:0] data_rdata_o;
   logic        data_err_o;
   logic        busy_o;
   logic [31:0] address_o;
   logic        read_o;
   logic        write_o;
   logic        waitrequest_i;
   logic [31:0] writedata_o;
   logic [3:0]  byteenable_o;
   logic [31:0] readdata_i;

   int n_cmp  = 0;
   int n_fail = 0;
   int cyc    = 0;
   int wait_cfg = 0;
   int sl_cnt = 0;
   bit sl_active = 1'b0;

   bus_exp_t  bus_q[$];
   resp_exp_t resp_q[$];

   mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk           (clk),
      .reset_i       (reset_i),
      .fetch_req_i   (fetch_req_i),
      .fetch_addr_i  (fetch_addr_i),
      .fetch_done_o  (fetch_done_o),
      .fetch_data_o  (fetch_data_o),
      .data_req_i    (data_req_i),
      .data_we_i     (data_we_i),
      .data_size_i   (data_size_i),
      .data_signed_i (data_signed_i),
      .data_addr_i   (data_addr_i),
      .data_wdata_i  (data_wdata_i),
      .data_done_o   (data_done_o),
      .data_rdata_o  (data_rdata_o),
      .data_err_o    (data_err_o),
      .busy_o        (busy_o),
      .address_o     (address_o),
      .read_o        (read_o),
      .write_o       (write_o),
      .waitrequest_i (waitrequest_i),
      .writedata_o   (writedata_o),
      .byteenable_o  (byteenable_o),
      .readdata_i    (readdata_i)
   );

   always #5 clk = ~clk;

   // Cycle counter used for latency expectations.
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic push_bus(input logic [31:0] a, input logic [3:0] be, input logic [31:0] wd, input logic we);
      bus_q.push_back('{a, be, wd, we});
   endtask

   task automatic push_resp(input bit f, input logic [31:0] d, input logic e, input int c);
      resp_q.push_back('{f, d, e, c});
   endtask

   // Bus slave: inserts wait_cfg wait states on every new strobe.
   always @(posedge clk) begin
      #1;
      if (read_o || write_o) begin
         if (!sl_active) begin
            sl_active = 1'b1;
            sl_cnt    = wait_cfg;
         end
         if (sl_cnt > 0) begin
            waitrequest_i = 1'b1;
            sl_cnt--;
         end else begin
            waitrequest_i = 1'b0;
         end
      end else begin
         sl_active     = 1'b0;
         waitrequest_i = 1'b0;
      end
   end

   // Bus monitor: every strobe cycle must match the head expectation; pop on release.
   always @(negedge clk) begin
      if (reset_i && (read_o || write_o)) begin
         if (bus_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_strobe: got read=%b write=%b addr %h want no strobe", read_o, write_o, address_o);
         end else begin
            chk("bus_addr", address_o, bus_q[0].addr);
            chk("bus_be", {28'b0, byteenable_o}, {28'b0, bus_q[0].be});
            chk("bus_wdata", writedata_o, bus_q[0].wd);
            chk("bus_write", {31'b0, write_o}, {31'b0, bus_q[0].we});
            chk("bus_read", {31'b0, read_o}, {31'b0, ~bus_q[0].we});
            if (!waitrequest_i) void'(bus_q.pop_front());
         end
      end
   end

   task automatic check_resp(input bit f);
      resp_exp_t r;
      if (resp_q.size() == 0) begin
         n_cmp++;
         n_fail++;
         $display("FAIL unexpected_done: got fetch=%b done pulse want none", f);
      end else begin
         r = resp_q.pop_front();
         chk("resp_kind", {31'b0, f}, {31'b0, r.is_fetch});
         chk("resp_cycle", cyc, r.cyc);
         if (f) begin
            chk("fetch_data", fetch_data_o, r.data);
         end else begin
            chk("data_rdata", data_rdata_o, r.data);
            chk("data_err", {31'b0, data_err_o}, {31'b0, r.err});
         end
      end
   endtask

   // Response monitor: pops the scoreboard on each completion pulse.
   always @(negedge clk) begin
      if (reset_i) begin
         if (fetch_done_o) check_resp(1'b1);
         if (data_done_o) check_resp(1'b0);
      end
   end

   task automatic do_fetch(input logic [31:0] a);
      bit got = 1'b0;
      fetch_req_i  = 1'b1;
      fetch_addr_i = a;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (fetch_done_o) begin
            got = 1'b1;
            break;
         end
      end
      if (!got) begin
         n_cmp++;
         n_fail++;
         $display("FAIL fetch_timeout: got no fetch_done_o want done for %h", a);
      end
      @(posedge clk);
      #1 fetch_req_i = 1'b0;
   endtask

   task automatic do_data(input logic we, input logic [1:0] sz, input logic sg,
                          input logic [31:0] a, input logic [31:0] wd);
      bit got = 1'b0;
      data_req_i    = 1'b1;
      data_we_i     = we;
      data_size_i   = sz;
      data_signed_i = sg;
      data_addr_i   = a;
      data_wdata_i  = wd;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (data_done_o) begin
            got = 1'b1;
            break;
         end
      end
      if (!got) begin
         n_cmp++;
         n_fail++;
         $display("FAIL data_timeout: got no data_done_o want done for %h", a);
      end
      @(posedge clk);
      #1 data_req_i = 1'b0;
   endtask

   // Issue one data access with hand-computed bus and response expectations.
   task automatic run_data(input logic we, input logic [1:0] sz, input logic sg, input logic [31:0] a,
                           input logic [31:0] wd, input int waits, input logic [31:0] rd,
                           input logic [3:0] exp_be, input logic [31:0] exp_wd,
                           input logic [31:0] exp_rd, input logic exp_err);
      @(posedge clk);
      #1;
      wait_cfg   = waits;
      readdata_i = rd;
      if (exp_err) begin
         push_resp(1'b0, 32'h0, 1'b1, cyc + 1);
      end else begin
         push_bus({a[31:2], 2'b00}, exp_be, exp_wd, we);
         push_resp(1'b0, exp_rd, 1'b0, cyc + 2 + waits);
      end
      do_data(we, sz, sg, a, wd);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got no finish want finish by 100000");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int c;
      bit seen;
      reset_i       = 1'b0;
      fetch_req_i   = 1'b0;
      fetch_addr_i  = '0;
      data_req_i    = 1'b0;
      data_we_i     = 1'b0;
      data_size_i   = '0;
      data_signed_i = 1'b0;
      data_addr_i   = '0;
      data_wdata_i  = '0;
      waitrequest_i = 1'b0;
      readdata_i    = '0;

      repeat (3) @(negedge clk);
      chk("rst_busy", {31'b0, busy_o}, 32'h0);
      chk("rst_read", {31'b0, read_o}, 32'h0);
      chk("rst_write", {31'b0, write_o}, 32'h0);
      chk("rst_addr", address_o, 32'h0);
      chk("rst_be", {28'b0, byteenable_o}, 32'h0);
      chk("rst_wdata", writedata_o, 32'h0);
      chk("rst_done", {30'b0, fetch_done_o, data_done_o}, 32'h0);
      chk("rst_rdata", data_rdata_o | fetch_data_o, 32'h0);
      chk("rst_err", {31'b0, data_err_o}, 32'h0);
      @(posedge clk);
      #1 reset_i = 1'b1;

      // Both requesters from reset: fetch first, then data, then fetch again.
      @(posedge clk);
      #1;
      c          = cyc;
      wait_cfg   = 0;
      readdata_i = 32'h11223344;
      push_bus(32'h100, 4'hF, 32'h0, 1'b0);
      push_bus(32'h200, 4'hF, 32'h0, 1'b0);
      push_bus(32'h104, 4'hF, 32'h0, 1'b0);
      push_resp(1'b1, 32'h44332211, 1'b0, c + 2);
      push_resp(1'b0, 32'h44332211, 1'b0, c + 5);
      push_resp(1'b1, 32'h44332211, 1'b0, c + 8);
      fork
         begin
            do_fetch(32'h100);
            do_fetch(32'h104);
         end
         do_data(1'b0, 2'd2, 1'b0, 32'h200, 32'h0);
      join

      // Boot-vector fetch, zero wait states.
      @(posedge clk);
      #1;
      wait_cfg   = 0;
      readdata_i = 32'h0800E0FF;
      push_bus(32'hBFC00000, 4'hF, 32'h0, 1'b0);
      push_resp(1'b1, 32'hFFE00008, 1'b0, cyc + 2);
      do_fetch(32'hBFC00000);

      // we, size, signed, addr, wdata, waits, readdata, be, bus wdata, rdata, err
      run_data(1'b1, 2'd0, 1'b0, 32'h1003, 32'h000000A5, 3, 32'h0, 4'b1000, 32'hA5000000, 32'h0, 1'b0);
      run_data(1'b0, 2'd0, 1'b1, 32'h2001, 32'h0, 0, 32'h00008000, 4'b0010, 32'h0, 32'hFFFFFF80, 1'b0);
      run_data(1'b0, 2'd0, 1'b0, 32'h2001, 32'h0, 0, 32'h00008000, 4'b0010, 32'h0, 32'h00000080, 1'b0);
      run_data(1'b0, 2'd1, 1'b1, 32'h2002, 32'h0, 0, 32'h34120000, 4'b1100, 32'h0, 32'h00001234, 1'b0);
      run_data(1'b0, 2'd1, 1'b1, 32'h2000, 32'h0, 2, 32'h000080FF, 4'b0011, 32'h0, 32'hFFFFFF80, 1'b0);
      run_data(1'b1, 2'd1, 1'b0, 32'h2002, 32'h0000BEEF, 1, 32'h0, 4'b1100, 32'hEFBE0000, 32'h0, 1'b0);
      run_data(1'b1, 2'd2, 1'b0, 32'h2004, 32'h12345678, 0, 32'h0, 4'b1111, 32'h78563412, 32'h0, 1'b0);
      run_data(1'b0, 2'd2, 1'b0, 32'h3002, 32'h0, 0, 32'h0, 4'b0000, 32'h0, 32'h0, 1'b1);
      run_data(1'b0, 2'd1, 1'b0, 32'h3001, 32'h0, 0, 32'h0, 4'b0000, 32'h0, 32'h0, 1'b1);
      run_data(1'b0, 2'd3, 1'b0, 32'h3000, 32'h0, 0, 32'h0, 4'b0000, 32'h0, 32'h0, 1'b1);

      // Reset while a fetch is stalled on the bus.
      @(posedge clk);
      #1;
      wait_cfg     = 20;
      readdata_i   = 32'h0;
      push_bus(32'h400, 4'hF, 32'h0, 1'b0);
      fetch_req_i  = 1'b1;
      fetch_addr_i = 32'h400;
      seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (read_o) begin
            seen = 1'b1;
            break;
         end
      end
      chk("midrst_strobe_seen", {31'b0, seen}, 32'h1);
      #2 reset_i = 1'b0;
      #1;
      chk("midrst_read", {31'b0, read_o}, 32'h0);
      chk("midrst_busy", {31'b0, busy_o}, 32'h0);
      chk("midrst_done", {30'b0, fetch_done_o, data_done_o}, 32'h0);
      chk("midrst_addr", address_o, 32'h0);
      chk("midrst_be", {28'b0, byteenable_o}, 32'h0);
      fetch_req_i = 1'b0;
      bus_q.delete();
      repeat (2) @(posedge clk);
      #1 reset_i = 1'b1;
      @(negedge clk);
      chk("postrst_busy", {31'b0, busy_o}, 32'h0);

      // Fresh fetch after recovery.
      @(posedge clk);
      #1;
      wait_cfg   = 0;
      readdata_i = 32'hDEADBEEF;
      push_bus(32'h500, 4'hF, 32'h0, 1'b0);
      push_resp(1'b1, 32'hEFBEADDE, 1'b0, cyc + 2);
      do_fetch(32'h500);

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("bus_q_drained", bus_q.size(), 32'h0);
      chk("resp_q_drained", resp_q.size(), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
